// File: rtl/fetch_writeback_if.sv
// Bus between the fetch/writeback sequencer and its environment.
// It carries the instruction-memory port and the execute-stage operand and
// commit signals.
//   master : the sequencer. It drives imem_addr, ins, pc, reg1 and reg2.
//            It receives imem_data, wra, result and nextpc.
//   slave  : the instruction memory and the execute stage (mirror image).
interface fetch_writeback_if #(
  parameter int unsigned IMEM_AW = 8
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        ins;
  logic [31:0]        pc;
  logic [31:0]        reg1;
  logic [31:0]        reg2;
  logic [4:0]         wra;
  logic [31:0]        result;
  logic [31:0]        nextpc;

  modport master (
    output imem_addr, ins, pc, reg1, reg2,
    input  imem_data, wra, result, nextpc
  );

  modport slave (
    input  imem_addr, ins, pc, reg1, reg2,
    output imem_data, wra, result, nextpc
  );
endinterface

// File: rtl/fetch_writeback.sv
// Fetch/writeback sequencer of the multi-cycle processor. Every instruction
// passes through four phases, so CPI is 4:
//   IF -> ID -> EX -> WB -> IF
// In IF the PC is sent to the instruction memory. In ID the instruction is
// captured and the register file is read. In EX the execute stage computes.
// In WB the PC update and the register write are committed.
// Ports:
//   clk      : clock; all state updates on the rising edge
//   rstd     : synchronous active-low reset
//   bus      : imem port, execute operands (ins/pc/reg1/reg2) and
//              commit inputs (wra/result/nextpc)
//   halt     : stall request, honoured only in IF
//   phase    : current phase (IF=0, ID=1, EX=2, WB=3)
//   retire   : high during the WB cycle
//   dbg_addr : debug register-read address
//   dbg_data : combinational register read (r0 reads 0)
module fetch_writeback #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic                   clk,
  input  logic                   rstd,
  fetch_writeback_if.master      bus,
  input  logic                   halt,
  output logic [1:0]             phase,
  output logic                   retire,
  input  logic [4:0]             dbg_addr,
  output logic [31:0]            dbg_data
);

  typedef enum logic [1:0] {
    S_IF = 2'd0,
    S_ID = 2'd1,
    S_EX = 2'd2,
    S_WB = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ins_q;
  logic [31:0] reg1_q;
  logic [31:0] reg2_q;
  logic        retire_q;
  logic [31:0] rf_q [32];

  logic [4:0]  rs;
  logic [4:0]  rt;

  assign rs = bus.imem_data[25:21];
  assign rt = bus.imem_data[20:16];

  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_q  <= S_IF;
      pc_q     <= RESET_PC;
      ins_q    <= '0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      retire_q <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IF: begin
          if (!halt) begin
            state_q <= S_ID;
          end
        end
        S_ID: begin
          // imem_data answers the address presented during IF.
          ins_q   <= bus.imem_data;
          reg1_q  <= (rs == 5'd0) ? '0 : rf_q[rs];
          reg2_q  <= (rt == 5'd0) ? '0 : rf_q[rt];
          state_q <= S_EX;
        end
        S_EX: begin
          // retire is registered, so it is set on the edge that enters WB.
          retire_q <= 1'b1;
          state_q  <= S_WB;
        end
        S_WB: begin
          pc_q <= bus.nextpc;
          if (bus.wra != 5'd0) begin
            rf_q[bus.wra] <= bus.result;
          end
          retire_q <= 1'b0;
          state_q  <= S_IF;
        end
        default: begin
          state_q <= S_IF;
        end
      endcase
    end
  end

  assign bus.imem_addr = pc_q[IMEM_AW-1:0];
  assign bus.ins       = ins_q;
  assign bus.pc        = pc_q;
  assign bus.reg1      = reg1_q;
  assign bus.reg2      = reg2_q;
  assign phase         = state_q;
  assign retire        = retire_q;
  assign dbg_data      = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_fetch_writeback.sv
// Randomized self-checking bench for fetch_writeback. It keeps a reference
// model of the architectural state: a register-file array and the PC.
// The bench updates that model once per retired instruction, directly from
// the commit rule: pc = nextpc, and rf[wra] = result unless wra is 0.
module tb_fetch_writeback;

  localparam logic [31:0] RESET_PC = 32'd0;

  int          passed;
  int          total;

  logic        clk;
  logic        rstd;
  logic        halt;
  logic [1:0]  phase;
  logic        retire;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [31:0] imem [256];
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;

  fetch_writeback_if #(.IMEM_AW(8)) bus ();

  fetch_writeback #(
    .RESET_PC (RESET_PC),
    .IMEM_AW  (8)
  ) dut (
    .clk      (clk),
    .rstd     (rstd),
    .bus      (bus),
    .halt     (halt),
    .phase    (phase),
    .retire   (retire),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory with a read latency of one cycle.
  always @(posedge clk) bus.imem_data <= imem[bus.imem_addr];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_pc = RESET_PC;
  endtask

  // Runs one instruction through all four phases. It is entered at a
  // negedge inside IF. It returns at the negedge of the next IF.
  task automatic run_instr(input logic [4:0] w, input logic [31:0] res, input logic [31:0] npc);
    logic [31:0] exp_ins;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [7:0]  exp_addr;
    exp_addr = m_pc[7:0];
    total++; if (phase !== 2'd0) $display("FAIL if_phase: got %0d expected 0", phase); else passed++;
    total++; if (retire !== 1'b0) $display("FAIL if_retire: got %b expected 0", retire); else passed++;
    total++; if (bus.imem_addr !== exp_addr) $display("FAIL if_imem_addr: got %h expected %h", bus.imem_addr, exp_addr); else passed++;
    exp_ins = imem[exp_addr];
    rs = exp_ins[25:21];
    rt = exp_ins[20:16];
    halt = 1'b0;
    bus.wra = w;
    bus.result = res;
    bus.nextpc = npc;
    @(negedge clk);
    total++; if (phase !== 2'd1) $display("FAIL id_phase: got %0d expected 1", phase); else passed++;
    // halt has no effect once the instruction has left IF.
    halt = 1'($urandom_range(0, 1));
    @(negedge clk);
    total++; if (phase !== 2'd2) $display("FAIL ex_phase: got %0d expected 2", phase); else passed++;
    total++; if (bus.ins !== exp_ins) $display("FAIL ex_ins: got %h expected %h", bus.ins, exp_ins); else passed++;
    total++; if (bus.reg1 !== m_rf[rs]) $display("FAIL ex_reg1: got %h expected %h (r%0d)", bus.reg1, m_rf[rs], rs); else passed++;
    total++; if (bus.reg2 !== m_rf[rt]) $display("FAIL ex_reg2: got %h expected %h (r%0d)", bus.reg2, m_rf[rt], rt); else passed++;
    total++; if (bus.pc !== m_pc) $display("FAIL ex_pc: got %h expected %h", bus.pc, m_pc); else passed++;
    halt = 1'($urandom_range(0, 1));
    @(negedge clk);
    total++; if (phase !== 2'd3) $display("FAIL wb_phase: got %0d expected 3", phase); else passed++;
    total++; if (retire !== 1'b1) $display("FAIL wb_retire: got %b expected 1", retire); else passed++;
    halt = 1'($urandom_range(0, 1));
    if (w != 5'd0) m_rf[w] = res;
    m_pc = npc;
    @(negedge clk);
    halt = 1'b0;
    total++; if (phase !== 2'd0) $display("FAIL next_if_phase: got %0d expected 0", phase); else passed++;
    total++; if (bus.pc !== m_pc) $display("FAIL commit_pc: got %h expected %h", bus.pc, m_pc); else passed++;
    dbg_addr = w;
    #1;
    total++; if (dbg_data !== m_rf[w]) $display("FAIL commit_rf: got %h expected %h (r%0d)", dbg_data, m_rf[w], w); else passed++;
  endtask

  task automatic test_reset();
    rstd = 1'b0;
    halt = 1'b0;
    bus.wra = 5'd0;
    bus.result = 32'd0;
    bus.nextpc = 32'd0;
    dbg_addr = 5'd0;
    repeat (2) @(negedge clk);
    model_reset();
    total++; if (phase !== 2'd0) $display("FAIL rst_phase: got %0d expected 0", phase); else passed++;
    total++; if (bus.pc !== RESET_PC) $display("FAIL rst_pc: got %h expected %h", bus.pc, RESET_PC); else passed++;
    total++; if (bus.imem_addr !== RESET_PC[7:0]) $display("FAIL rst_imem_addr: got %h expected %h", bus.imem_addr, RESET_PC[7:0]); else passed++;
    total++; if (bus.ins !== 32'd0) $display("FAIL rst_ins: got %h expected 0", bus.ins); else passed++;
    total++; if (bus.reg1 !== 32'd0) $display("FAIL rst_reg1: got %h expected 0", bus.reg1); else passed++;
    total++; if (bus.reg2 !== 32'd0) $display("FAIL rst_reg2: got %h expected 0", bus.reg2); else passed++;
    total++; if (retire !== 1'b0) $display("FAIL rst_retire: got %b expected 0", retire); else passed++;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      total++; if (dbg_data !== 32'd0) $display("FAIL rst_dbg: got %h expected 0 (r%0d)", dbg_data, i); else passed++;
    end
    @(negedge clk);
    rstd = 1'b1;
  endtask

  task automatic test_single_commit();
    run_instr(5'd1, 32'd5, 32'd1);
    total++; if (bus.imem_addr !== 8'd1) $display("FAIL single_imem_addr: got %h expected 01", bus.imem_addr); else passed++;
    dbg_addr = 5'd1;
    #1;
    total++; if (dbg_data !== 32'd5) $display("FAIL single_r1: got %h expected 5", dbg_data); else passed++;
  endtask

  task automatic test_dependency();
    // imem[1] uses r1 as rs, and r1 was written by the previous instruction.
    // run_instr checks that reg1 in EX equals the model's r1, which is 5.
    run_instr(5'd2, $urandom, 32'd2);
    total++; if (m_rf[1] !== 32'd5 || bus.pc !== 32'd2) $display("FAIL dep_state: pc %h expected 2", bus.pc); else passed++;
  endtask

  task automatic test_r0_branch();
    run_instr(5'd0, 32'hdeadbeef, 32'h20);
    dbg_addr = 5'd0;
    #1;
    total++; if (dbg_data !== 32'd0) $display("FAIL r0_write: got %h expected 0", dbg_data); else passed++;
    total++; if (bus.imem_addr !== 8'h20) $display("FAIL branch_imem_addr: got %h expected 20", bus.imem_addr); else passed++;
  endtask

  task automatic test_halt();
    logic [31:0] pc0;
    pc0 = bus.pc;
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (phase !== 2'd0) $display("FAIL halt_phase: got %0d expected 0", phase); else passed++;
      total++; if (bus.pc !== pc0) $display("FAIL halt_pc: got %h expected %h", bus.pc, pc0); else passed++;
      total++; if (retire !== 1'b0) $display("FAIL halt_retire: got %b expected 0", retire); else passed++;
    end
    run_instr(5'($urandom), $urandom, m_pc + 32'd1);
  endtask

  task automatic test_pc_wrap();
    run_instr(5'($urandom), $urandom, 32'hffffffff);
    total++; if (bus.imem_addr !== 8'hff) $display("FAIL wrap_imem_addr: got %h expected ff", bus.imem_addr); else passed++;
    run_instr(5'($urandom), $urandom, m_pc + 32'd1);
    total++; if (bus.pc !== 32'd0) $display("FAIL wrap_pc: got %h expected 0", bus.pc); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] npc;
    for (int n = 0; n < 40; n++) begin
      int unsigned stall;
      stall = $urandom_range(0, 2);
      halt = (stall != 0);
      for (int unsigned s = 0; s < stall; s++) begin
        @(negedge clk);
        total++; if (phase !== 2'd0) $display("FAIL rnd_halt_phase: got %0d expected 0", phase); else passed++;
      end
      npc = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd1;
      run_instr(5'($urandom), $urandom, npc);
    end
  endtask

  task automatic test_reset_mid();
    halt = 1'b0;
    bus.wra = 5'd3;
    bus.result = 32'd7;
    bus.nextpc = 32'h55;
    @(negedge clk);
    @(negedge clk);
    total++; if (phase !== 2'd2) $display("FAIL mid_pre_phase: got %0d expected 2", phase); else passed++;
    rstd = 1'b0;
    @(negedge clk);
    model_reset();
    total++; if (phase !== 2'd0) $display("FAIL mid_phase: got %0d expected 0", phase); else passed++;
    total++; if (bus.pc !== RESET_PC) $display("FAIL mid_pc: got %h expected %h", bus.pc, RESET_PC); else passed++;
    total++; if (retire !== 1'b0) $display("FAIL mid_retire: got %b expected 0", retire); else passed++;
    dbg_addr = 5'd3;
    #1;
    total++; if (dbg_data !== 32'd0) $display("FAIL mid_r3: got %h expected 0", dbg_data); else passed++;
    rstd = 1'b1;
    run_instr(5'd4, 32'h1234, 32'd1);
  endtask

  initial begin
    passed = 0;
    total = 0;
    rstd = 1'b0;
    halt = 1'b0;
    dbg_addr = 5'd0;
    bus.wra = 5'd0;
    bus.result = 32'd0;
    bus.nextpc = 32'd0;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h04010005;
    imem[1] = 32'h00221820;
    model_reset();

    test_reset();
    test_single_commit();
    test_dependency();
    test_r0_branch();
    test_halt();
    test_pc_wrap();
    test_back_to_back();
    test_reset_mid();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
